// File: rtl/oam_dma_ctrl_if.sv
// CPU/bus side signals of the sprite DMA sequencer.
// master is the DMA controller; slave is the CPU top level that feeds and muxes it.
interface oam_dma_ctrl_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_we;
  logic [7:0]  bus_data_in;
  logic        rdy_n;
  logic        bus_sel;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data_out;
  logic        dma_we;
  logic        dma_active;
  logic        done;

  modport master (
    input  cpu_addr, cpu_data_out, cpu_we, bus_data_in,
    output rdy_n, bus_sel, dma_addr, dma_data_out, dma_we, dma_active, done
  );

  modport slave (
    output cpu_addr, cpu_data_out, cpu_we, bus_data_in,
    input  rdy_n, bus_sel, dma_addr, dma_data_out, dma_we, dma_active, done
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer: a CPU write to $4014 copies page {data,00} into OAMDATA,
// stalling the CPU and owning the bus for the duration of the copy.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [15:0] OAMDATA_ADDR = 16'h2004,
  parameter int unsigned XFER_LEN     = 256
) (
  input  logic           clk,
  input  logic           reset,
  oam_dma_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t      state_r;
  logic [7:0]  page_r;
  logic [7:0]  idx_r;
  logic        odd_r;
  logic        rdy_n_r;
  logic        bus_sel_r;
  logic [15:0] dma_addr_r;
  logic [7:0]  dma_data_out_r;
  logic        dma_we_r;
  logic        dma_active_r;
  logic        done_r;
  logic        trigger_s;
  logic        last_idx_s;

  assign trigger_s  = bus.cpu_we && (bus.cpu_addr == DMA_REG_ADDR);
  assign last_idx_s = (idx_r == 8'(XFER_LEN - 32'd1));

  // Sequencer FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      page_r         <= 8'h00;
      idx_r          <= 8'h00;
      odd_r          <= 1'b0;
      rdy_n_r        <= 1'b1;
      bus_sel_r      <= 1'b0;
      dma_addr_r     <= 16'h0000;
      dma_data_out_r <= 8'h00;
      dma_we_r       <= 1'b0;
      dma_active_r   <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      odd_r  <= ~odd_r;
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (trigger_s) begin
            state_r      <= HALT;
            page_r       <= bus.cpu_data_out;
            idx_r        <= 8'h00;
            rdy_n_r      <= 1'b0;
            dma_active_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        HALT: begin
          // An odd cycle at HALT costs one extra ALIGN cycle before the first read.
          if (odd_r) begin
            state_r <= ALIGN;
          end else begin
            state_r    <= READ;
            bus_sel_r  <= 1'b1;
            dma_addr_r <= {page_r, idx_r};
          end
        end
        ALIGN: begin
          state_r    <= READ;
          bus_sel_r  <= 1'b1;
          dma_addr_r <= {page_r, idx_r};
        end
        READ: begin
          state_r        <= WRITE;
          dma_addr_r     <= OAMDATA_ADDR;
          dma_data_out_r <= bus.bus_data_in;
          dma_we_r       <= 1'b1;
        end
        WRITE: begin
          dma_we_r <= 1'b0;
          if (last_idx_s) begin
            state_r        <= IDLE;
            done_r         <= 1'b1;
            rdy_n_r        <= 1'b1;
            bus_sel_r      <= 1'b0;
            dma_active_r   <= 1'b0;
            dma_addr_r     <= 16'h0000;
            dma_data_out_r <= 8'h00;
          end else begin
            // idx wraps inside the page only; page never carries.
            state_r    <= READ;
            idx_r      <= idx_r + 8'd1;
            dma_addr_r <= {page_r, idx_r + 8'd1};
          end
        end
        default: begin
          state_r        <= IDLE;
          rdy_n_r        <= 1'b1;
          bus_sel_r      <= 1'b0;
          dma_addr_r     <= 16'h0000;
          dma_data_out_r <= 8'h00;
          dma_we_r       <= 1'b0;
          dma_active_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rdy_n        = rdy_n_r;
  assign bus.bus_sel      = bus_sel_r;
  assign bus.dma_addr     = dma_addr_r;
  assign bus.dma_data_out = dma_data_out_r;
  assign bus.dma_we       = dma_we_r;
  assign bus.dma_active   = dma_active_r;
  assign bus.done         = done_r;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized scoreboard bench for oam_dma_ctrl: a transfer-level model predicts
// the stall window and the read/write streams; a negedge monitor compares.
module tb_oam_dma_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  oam_dma_ctrl_if bus();

  oam_dma_ctrl u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [7:0] mem [0:65535];
  assign bus.bus_data_in = mem[bus.dma_addr];

  int vectors     = 0;
  int miscompares = 0;
  int n_we        = 0;

  // Transfer-level model: cycles left in the stall, phase of the CPU clock, expected streams.
  int          busy_cnt = 0;
  logic        odd_m    = 1'b0;
  logic        done_m   = 1'b0;
  logic [15:0] rdq [$];
  logic [7:0]  wrq [$];
  logic [4:0]  exp_ctl;
  logic [4:0]  act_ctl;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: a trigger in idle schedules 513 or 514 stall cycles and 256 byte moves.
  always @(posedge clk) begin
    if (reset) begin
      busy_cnt <= 0;
      odd_m    <= 1'b0;
      done_m   <= 1'b0;
      rdq.delete();
      wrq.delete();
    end else begin
      odd_m  <= ~odd_m;
      done_m <= (busy_cnt == 1);
      if (busy_cnt > 0) begin
        busy_cnt <= busy_cnt - 1;
      end else if (bus.cpu_we === 1'b1 && bus.cpu_addr === 16'h4014) begin
        busy_cnt <= 513 + (odd_m ? 0 : 1);
        for (int i = 0; i < 256; i++) begin
          rdq.push_back({bus.cpu_data_out, 8'(i)});
          wrq.push_back(mem[{bus.cpu_data_out, 8'(i)}]);
        end
      end
    end
  end

  // Monitor: per-cycle control check plus in-order read/write stream check.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        exp_ctl = {busy_cnt == 0, busy_cnt > 0, busy_cnt > 0 && busy_cnt <= 512,
                   busy_cnt > 0 && busy_cnt <= 512 && (busy_cnt % 2) == 1, done_m};
        act_ctl = {bus.rdy_n, bus.dma_active, bus.bus_sel, bus.dma_we, bus.done};
        check("ctl rdy_n/active/sel/we/done", 64'(act_ctl), 64'(exp_ctl));
        if (busy_cnt == 0)
          check("idle_bus", {bus.dma_addr, bus.dma_data_out}, 64'h0);
        if (bus.dma_we === 1'b1) begin
          check("wr_pending", 64'(wrq.size() != 0), 64'h1);
          if (wrq.size() != 0) begin
            n_we++;
            check("wr_addr", 64'(bus.dma_addr), 64'h2004);
            check("wr_data", 64'(bus.dma_data_out), 64'(wrq.pop_front()));
          end
        end
        if (bus.bus_sel === 1'b1 && bus.dma_we === 1'b0) begin
          check("rd_pending", 64'(rdq.size() != 0), 64'h1);
          if (rdq.size() != 0)
            check("rd_addr", 64'(bus.dma_addr), 64'(rdq.pop_front()));
        end
        if (done_m)
          check("done_leftover", 64'(rdq.size() + wrq.size()), 64'h0);
      end
    end
  end

  task automatic trigger(input logic [7:0] page, input logic want_align);
    for (int k = 0; k < 4 && odd_m !== !want_align; k++) @(negedge clk);
    bus.cpu_we       = 1'b1;
    bus.cpu_addr     = 16'h4014;
    bus.cpu_data_out = page;
    @(negedge clk);
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h0000;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (k < budget && !(busy_cnt == 0 && bus.rdy_n === 1'b1)) begin
      @(negedge clk);
      k++;
    end
    check("xfer_end", 64'(busy_cnt == 0 && bus.rdy_n === 1'b1), 64'h1);
  endtask

  initial begin
    int base;
    int k;
    reset            = 1'b1;
    bus.cpu_addr     = 16'h0000;
    bus.cpu_data_out = 8'h00;
    bus.cpu_we       = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {bus.rdy_n, bus.bus_sel, bus.dma_we, bus.dma_addr, bus.done},
          {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Page 02, even and odd start.
    trigger(8'h02, 1'b0);
    wait_done(700);
    trigger(8'h02, 1'b1);
    wait_done(700);

    // Last page: reads must stay in FF00..FFFF.
    trigger(8'hFF, 1'($urandom));
    wait_done(700);

    // Non-triggers while idle, then bus noise during a page-02 transfer.
    bus.cpu_we = 1'b0; bus.cpu_addr = 16'h4014; bus.cpu_data_out = 8'h03;
    @(negedge clk);
    bus.cpu_we = 1'b1; bus.cpu_addr = 16'h4015;
    @(negedge clk);
    bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000;
    repeat (3) @(negedge clk);
    trigger(8'h02, 1'($urandom));
    k = 0;
    while (busy_cnt > 0 && k < 600) begin
      bus.cpu_we       = 1'($urandom);
      bus.cpu_addr     = ($urandom_range(0, 1) == 0) ? 16'h4014 : 16'($urandom);
      bus.cpu_data_out = 8'h03;
      @(negedge clk);
      k++;
    end
    bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000;
    wait_done(700);

    // Reset after the 100th write, then restart on page 05.
    trigger(8'h05, 1'($urandom));
    base = n_we;
    k = 0;
    while (n_we < base + 100 && k < 400) begin
      @(posedge clk);
      k++;
    end
    check("hundred_writes", 64'(n_we - base), 64'd100);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_mid", {bus.rdy_n, bus.bus_sel, bus.done}, 3'b100);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    trigger(8'h05, 1'($urandom));
    wait_done(700);

    // Random pages.
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(1, 6)) @(negedge clk);
      trigger(8'($urandom), 1'($urandom));
      wait_done(700);
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
